// File: rtl/alu_inst_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : alu_inst_sequencer_if
// Brief    : Instruction handshake and datapath control bundle for the sequencer.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface alu_inst_sequencer_if #(
  parameter int CNT_W = 16
) ();
  logic [31:0]      Inst_In;
  logic             Inst_Valid;
  logic             Inst_Ready;
  logic             ZF;
  logic             OF;
  logic [4:0]       R_Addr_A;
  logic [4:0]       R_Addr_B;
  logic [4:0]       W_Addr;
  logic [2:0]       ALU_OP;
  logic             Write_Reg;
  logic             Flag_ZF;
  logic             Flag_OF;
  logic             Err;
  logic [CNT_W-1:0] Inst_Cnt;

  modport master (
    output Inst_In, Inst_Valid, ZF, OF,
    input  Inst_Ready, R_Addr_A, R_Addr_B, W_Addr, ALU_OP,
           Write_Reg, Flag_ZF, Flag_OF, Err, Inst_Cnt
  );

  modport slave (
    input  Inst_In, Inst_Valid, ZF, OF,
    output Inst_Ready, R_Addr_A, R_Addr_B, W_Addr, ALU_OP,
           Write_Reg, Flag_ZF, Flag_OF, Err, Inst_Cnt
  );
endinterface
`default_nettype wire

// File: rtl/alu_inst_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : alu_inst_sequencer
// Brief    : Decodes MIPS R-type instructions and sequences them through
//            DECODE/EXEC/WB, pulsing the register-file write at writeback.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module alu_inst_sequencer #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             Reset,
  alu_inst_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  localparam logic [5:0]       c_funct_and  = 6'h24;
  localparam logic [5:0]       c_funct_or   = 6'h25;
  localparam logic [5:0]       c_funct_xor  = 6'h26;
  localparam logic [5:0]       c_funct_nor  = 6'h27;
  localparam logic [5:0]       c_funct_add  = 6'h20;
  localparam logic [5:0]       c_funct_sub  = 6'h22;
  localparam logic [5:0]       c_funct_slt  = 6'h2A;
  localparam logic [5:0]       c_funct_sllv = 6'h04;
  localparam logic [CNT_W-1:0] c_cnt_one    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_opcode;
  logic [5:0]       r_funct;
  logic [4:0]       r_addr_a;
  logic [4:0]       r_addr_b;
  logic [4:0]       r_w_addr;
  logic [2:0]       r_alu_op;
  logic             r_write_reg;
  logic             r_err;
  logic             r_flag_zf;
  logic             r_flag_of;
  logic [CNT_W-1:0] r_inst_cnt;
  logic             w_legal;
  logic [2:0]       w_op;
  logic             w_unused_shamt;

  // Only opcode and funct of IR are needed after accept; the register
  // fields go straight into the address registers, shamt is don't-care.
  assign w_unused_shamt = ^bus.Inst_In[10:6];

  always_comb begin
    w_legal = 1'b0;
    w_op    = 3'b000;
    if (r_opcode == 6'd0) begin
      case (r_funct)
        c_funct_and:  begin w_legal = 1'b1; w_op = 3'b000; end
        c_funct_or:   begin w_legal = 1'b1; w_op = 3'b001; end
        c_funct_xor:  begin w_legal = 1'b1; w_op = 3'b010; end
        c_funct_nor:  begin w_legal = 1'b1; w_op = 3'b011; end
        c_funct_add:  begin w_legal = 1'b1; w_op = 3'b100; end
        c_funct_sub:  begin w_legal = 1'b1; w_op = 3'b101; end
        c_funct_slt:  begin w_legal = 1'b1; w_op = 3'b110; end
        c_funct_sllv: begin w_legal = 1'b1; w_op = 3'b111; end
        default:      begin w_legal = 1'b0; w_op = 3'b000; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.Inst_Valid) w_next = S_DECODE;
      S_DECODE: w_next = w_legal ? S_EXEC : S_IDLE;
      S_EXEC:   w_next = S_WB;
      S_WB:     w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Pulse outputs default low every cycle and are raised on the edge that
  // leaves the deciding state, so each is exactly one cycle wide.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_opcode    <= 6'd0;
      r_funct     <= 6'd0;
      r_addr_a    <= 5'd0;
      r_addr_b    <= 5'd0;
      r_w_addr    <= 5'd0;
      r_alu_op    <= 3'd0;
      r_write_reg <= 1'b0;
      r_err       <= 1'b0;
      r_flag_zf   <= 1'b0;
      r_flag_of   <= 1'b0;
      r_inst_cnt  <= '0;
    end else begin
      r_write_reg <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.Inst_Valid) begin
            r_opcode <= bus.Inst_In[31:26];
            r_funct  <= bus.Inst_In[5:0];
            r_addr_a <= bus.Inst_In[25:21];
            r_addr_b <= bus.Inst_In[20:16];
            r_w_addr <= bus.Inst_In[15:11];
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_alu_op <= w_op;
          end else begin
            r_err <= 1'b1;
          end
        end
        S_EXEC: begin
          r_flag_zf <= bus.ZF;
          r_flag_of <= bus.OF;
        end
        S_WB: begin
          // Writes to $0 are suppressed but still retire the instruction.
          r_write_reg <= (r_w_addr != 5'd0);
          r_inst_cnt  <= r_inst_cnt + c_cnt_one;
        end
        default: begin
          r_write_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Inst_Ready = (r_state == S_IDLE);
  assign bus.R_Addr_A   = r_addr_a;
  assign bus.R_Addr_B   = r_addr_b;
  assign bus.W_Addr     = r_w_addr;
  assign bus.ALU_OP     = r_alu_op;
  assign bus.Write_Reg  = r_write_reg;
  assign bus.Err        = r_err;
  assign bus.Flag_ZF    = r_flag_zf;
  assign bus.Flag_OF    = r_flag_of;
  assign bus.Inst_Cnt   = r_inst_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_inst_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_alu_inst_sequencer
// Brief    : Directed plus randomized checks of alu_inst_sequencer against a
//            transaction-level model of decode, timing, flags and counting.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_alu_inst_sequencer;

  localparam int TB_CNT_W = 4;
  localparam int c_period = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state for the architecturally visible registers.
  logic [TB_CNT_W-1:0] m_cnt = '0;
  logic                m_zf  = 1'b0;
  logic                m_of  = 1'b0;
  logic [2:0]          m_op  = 3'd0;
  time                 last_acc = 0;
  bit                  have_prev = 1'b0;
  int                  exp_gap = 4;

  logic [5:0] ref_funct [8] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h20, 6'h22, 6'h2A, 6'h04};

  always #(c_period/2) clk = ~clk;

  alu_inst_sequencer_if #(.CNT_W(TB_CNT_W)) ifc ();

  alu_inst_sequencer #(.CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .Reset (rst),
    .bus   (ifc)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [31:0] w, output bit legal, output logic [2:0] op);
    legal = 1'b0;
    op    = 3'd0;
    if (w[31:26] == 6'd0)
      for (int i = 0; i < 8; i++)
        if (w[5:0] == ref_funct[i]) begin
          legal = 1'b1;
          op    = 3'(i);
        end
  endfunction

  function automatic logic [31:0] rand_inst();
    int          k = $urandom_range(0, 9);
    logic [31:0] w = $urandom;
    if (k < 7) begin
      w[31:26] = 6'd0;
      w[5:0]   = ref_funct[$urandom_range(0, 7)];
      if ($urandom_range(0, 4) == 0) w[15:11] = 5'd0;
    end else if (k == 7) begin
      w[31:26] = 6'd0;
    end
    return w;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_ra"},  32'(ifc.R_Addr_A),  32'd0);
    check({tag, "_rb"},  32'(ifc.R_Addr_B),  32'd0);
    check({tag, "_wa"},  32'(ifc.W_Addr),    32'd0);
    check({tag, "_op"},  32'(ifc.ALU_OP),    32'd0);
    check({tag, "_wr"},  32'(ifc.Write_Reg), 32'd0);
    check({tag, "_err"}, 32'(ifc.Err),       32'd0);
    check({tag, "_zf"},  32'(ifc.Flag_ZF),   32'd0);
    check({tag, "_of"},  32'(ifc.Flag_OF),   32'd0);
    check({tag, "_cnt"}, 32'(ifc.Inst_Cnt),  32'd0);
  endtask

  task automatic rand_flags();
    ifc.ZF = 1'($urandom);
    ifc.OF = 1'($urandom);
  endtask

  // Called just after a falling edge with the DUT idle. zf_mode 1 forces ZF=1
  // during EXEC, otherwise flags are random.
  task automatic run_inst(input logic [31:0] w, input bit hold, input int zf_mode);
    bit         legal;
    logic [2:0] op;
    logic       exp_zf;
    logic       exp_of;
    time        acc_t;
    ref_decode(w, legal, op);
    check("ready_idle", 32'(ifc.Inst_Ready), 32'd1);
    ifc.Inst_In    = w;
    ifc.Inst_Valid = 1'b1;
    rand_flags();
    @(posedge clk);
    acc_t = $time;
    if (have_prev) check("accept_gap", 32'((acc_t - last_acc) / c_period), 32'(exp_gap));
    last_acc  = acc_t;
    have_prev = 1'b1;
    #1;
    if (!hold) ifc.Inst_Valid = 1'b0;

    @(negedge clk);
    check("dec_ready", 32'(ifc.Inst_Ready), 32'd0);
    check("dec_ra",    32'(ifc.R_Addr_A),   32'(w[25:21]));
    check("dec_rb",    32'(ifc.R_Addr_B),   32'(w[20:16]));
    check("dec_wa",    32'(ifc.W_Addr),     32'(w[15:11]));
    check("dec_wr",    32'(ifc.Write_Reg),  32'd0);
    check("dec_err",   32'(ifc.Err),        32'd0);
    rand_flags();

    @(negedge clk);
    if (!legal) begin
      check("ill_err",   32'(ifc.Err),        32'd1);
      check("ill_ready", 32'(ifc.Inst_Ready), 32'd1);
      check("ill_wr",    32'(ifc.Write_Reg),  32'd0);
      check("ill_cnt",   32'(ifc.Inst_Cnt),   32'(m_cnt));
      check("ill_zf",    32'(ifc.Flag_ZF),    32'(m_zf));
      check("ill_of",    32'(ifc.Flag_OF),    32'(m_of));
      check("ill_op",    32'(ifc.ALU_OP),     32'(m_op));
      ifc.Inst_Valid = 1'b0;
      exp_gap = 2;
      return;
    end
    m_op = op;
    check("exe_op",    32'(ifc.ALU_OP),     32'(m_op));
    check("exe_ready", 32'(ifc.Inst_Ready), 32'd0);
    check("exe_wr",    32'(ifc.Write_Reg),  32'd0);
    check("exe_err",   32'(ifc.Err),        32'd0);
    check("exe_zf",    32'(ifc.Flag_ZF),    32'(m_zf));
    rand_flags();
    if (zf_mode == 1) ifc.ZF = 1'b1;
    exp_zf = ifc.ZF;
    exp_of = ifc.OF;

    @(negedge clk);
    m_zf = exp_zf;
    m_of = exp_of;
    check("wb_zf",    32'(ifc.Flag_ZF),    32'(m_zf));
    check("wb_of",    32'(ifc.Flag_OF),    32'(m_of));
    check("wb_wr",    32'(ifc.Write_Reg),  32'd0);
    check("wb_ready", 32'(ifc.Inst_Ready), 32'd0);
    check("wb_op",    32'(ifc.ALU_OP),     32'(m_op));
    rand_flags();

    @(negedge clk);
    m_cnt = m_cnt + 1'b1;
    check("ret_wr",    32'(ifc.Write_Reg),  32'(w[15:11] != 5'd0));
    check("ret_cnt",   32'(ifc.Inst_Cnt),   32'(m_cnt));
    check("ret_ready", 32'(ifc.Inst_Ready), 32'd1);
    check("ret_err",   32'(ifc.Err),        32'd0);
    check("ret_ra",    32'(ifc.R_Addr_A),   32'(w[25:21]));
    ifc.Inst_Valid = 1'b0;
    exp_gap = 4;
  endtask

  task automatic reset_mid_exec();
    ifc.Inst_In    = 32'h00430820;
    ifc.Inst_Valid = 1'b1;
    @(posedge clk);
    #1 ifc.Inst_Valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("rst_exec");
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_wr", 32'(ifc.Write_Reg), 32'd0);
    end
    rst   = 1'b0;
    m_cnt = '0;
    m_zf  = 1'b0;
    m_of  = 1'b0;
    m_op  = 3'd0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_wr",  32'(ifc.Write_Reg), 32'd0);
      check("post_rst_cnt", 32'(ifc.Inst_Cnt),  32'd0);
    end
    have_prev = 1'b0;
  endtask

  initial begin
    #(c_period * 20000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifc.Inst_In    = 32'd0;
    ifc.Inst_Valid = 1'b0;
    ifc.ZF         = 1'b0;
    ifc.OF         = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("post_rst");
    check("post_rst_ready", 32'(ifc.Inst_Ready), 32'd1);

    run_inst(32'h00011820, 1'b0, 0);
    run_inst(32'h00640822, 1'b0, 1);
    run_inst(32'hFC000000, 1'b0, 0);
    run_inst(32'h00220020, 1'b0, 0);
    reset_mid_exec();
    run_inst(32'h00011820, 1'b1, 0);
    run_inst(32'h00640822, 1'b1, 0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        have_prev = 1'b0;
      end
      run_inst(rand_inst(), 1'($urandom), 0);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
